agu_exec: RTL and testbench
===========================

# agu_exec

Address-generation and memory-access execute stage sitting directly behind the AGU issue queue. It accepts one selected memory instruction per cycle when not busy, reads its operands, computes the effective address, and performs loads, buffered stores and cache/TLB maintenance operations. It produces the back-pressure signals the queue consumes (`AGU_busy`, `store_buffer_full`, `CACOP_already`, `INVTLB_already`) and writes results back to the ROB.

## Interface
- `SB_DEPTH`, 4: store-buffer entries (power of two, ≥2)
- `clk  in  1  clock`
- `rst  in  1  synchronous, active-high reset`
- `flush  in  1  pipeline flush`
- `AGU_select_vld/op/imm/dest_en/dest/source1/source2/ROB_ID  in  1/4/17/1/7/7/7/6  selected instruction from issue queue`
- `rf_raddr1, rf_raddr2  out  7  combinational copies of AGU_select_source1/2`
- `rf_rdata1, rf_rdata2  in  32  same-cycle register read data`
- `AGU_busy  out  1  block all memory issue`
- `store_buffer_full  out  1  SB count == SB_DEPTH`
- `CACOP_already, INVTLB_already  out  1  maintenance op of that kind in flight`
- `store_commit  in  1  oldest uncommitted SB entry retired by ROB`
- `mem_req_vld  out  1`; `mem_req_rdy  in  1`; `mem_req_we  out  1`; `mem_req_addr  out  32`; `mem_req_wdata  out  32`; `mem_req_wstrb  out  4`
- `mem_resp_vld  in  1`; `mem_resp_data  in  32`
- `maint_req_vld  out  1`; `maint_is_tlb  out  1`; `maint_addr  out  32`; `maint_done  in  1`
- `wb_vld, wb_dest_en, wb_dest, wb_data, wb_ROB_ID, wb_exc  out  1/1/7/32/6/1  completion to ROB/PRF`

## Operation
- Accept when `AGU_select_vld && !AGU_busy`; addr = `rf_rdata1 + sext32(imm)` mod 2^32.
- Op encodings: LD_B 0, LD_H 1, LD_W 2, LD_BU 3, LD_HU 4, ST_B 5, ST_H 6, ST_W 7, CACOP 8, INVTLB 9; others complete with `wb_exc`=1.
- Stores: push {addr&~3, rdata2 shifted to addr[1:0], wstrb} into SB, uncommitted; complete (`wb_vld`, `wb_dest_en`=0) next cycle. `store_commit` marks oldest uncommitted entry committed (ignored if none).
- SB drain: committed head issued with `mem_req_we`=1 whenever state is IDLE or WAIT_SB; popped on `mem_req_rdy`. No forwarding.
- FSM: IDLE; WAIT_SB (load/maint held until SB empty); LD_REQ (`mem_req_vld`, we=0, until rdy); LD_RESP (until `mem_resp_vld`, then wb with byte/half extracted by addr[1:0], sign/zero extended, → IDLE); MAINT (`maint_req_vld` held until `maint_done`, wb → IDLE).
- Load/maint from IDLE: → WAIT_SB if SB non-empty, else LD_REQ/MAINT.
- `AGU_busy` = state≠IDLE or committed SB head present.
- `CACOP_already`/`INVTLB_already` high from accept of that op until cycle after `maint_done`.
- Flush: uncommitted SB entries discarded, committed kept; WAIT_SB/LD_REQ → IDLE (no wb); LD_RESP → IDLE with drop flag discarding next `mem_resp_vld`; MAINT stays until `maint_done`, wb suppressed. Accept in flush cycle ignored.

## Timing
- Reset: state IDLE, SB empty, drop flag 0; all outputs 0 except address/data outputs 0.
- Store: accept T → `wb_vld` T+1, SB count visible T+1.
- Load, SB empty, rdy=1: accept T → `mem_req_vld` T+1 → resp at R → `wb_vld` R+1.
- `store_commit` and SB pop same cycle both take effect.
- `store_buffer_full` registered-count based; never pushes when full (queue guarantees; push when full dropped and asserted in simulation).

## Configuration
- `AGU_MISALIGN_CHECK_EN` defined: half at odd addr or word with addr[1:0]≠0 → no SB push/memory request, wb next cycle with `wb_exc`=1. Undefined: low bits forced to alignment, no exception.

## Structure
- Shared package: op encodings, `SB_DEPTH` default, FSM state enum, SB entry struct.
- Sub-module `agu_store_buffer`: circular FIFO with head/tail/commit pointers, wrap-around, flush rollback of tail to commit pointer.

## Test plan
- LD_W, rdata1=0x1000, imm=0x1FFFC (−4) → req addr 0x0FFC, resp 0xDEADBEEF → wb_data 0xDEADBEEF at resp+1.
- LD_B addr 0x2003, resp 0x80000000 → wb_data 0xFFFFFF80; LD_BU same → 0x00000080.
- Four ST_W, no commit → `store_buffer_full`=1; two `store_commit` → two we=1 requests drain, full deasserts.
- ST_B then LD_W: load held in WAIT_SB until commit and drain, then read issued.
- Flush during LD_RESP → no wb, late resp dropped; next load writes back normally.
- CACOP accept → `CACOP_already`=1, `AGU_busy`=1 until maint_done+1.

Source files
------------

// File: rtl/agu_exec_pkg.sv
// Shared definitions for the AGU execute stage: op encodings, store-buffer
// entry layout, FSM states and the byte-lane helpers used by loads and stores.
package agu_exec_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;

    localparam logic [3:0] OP_LD_B   = 4'd0;
    localparam logic [3:0] OP_LD_H   = 4'd1;
    localparam logic [3:0] OP_LD_W   = 4'd2;
    localparam logic [3:0] OP_LD_BU  = 4'd3;
    localparam logic [3:0] OP_LD_HU  = 4'd4;
    localparam logic [3:0] OP_ST_B   = 4'd5;
    localparam logic [3:0] OP_ST_H   = 4'd6;
    localparam logic [3:0] OP_ST_W   = 4'd7;
    localparam logic [3:0] OP_CACOP  = 4'd8;
    localparam logic [3:0] OP_INVTLB = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SB,
        S_LD_REQ,
        S_LD_RESP,
        S_MAINT
    } agu_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } sb_entry_t;

    // 0 = byte, 1 = half, 2 = word
    function automatic logic [1:0] access_size(input logic [3:0] op);
        case (op)
            OP_LD_B, OP_LD_BU, OP_ST_B: access_size = 2'd0;
            OP_LD_H, OP_LD_HU, OP_ST_H: access_size = 2'd1;
            default:                    access_size = 2'd2;
        endcase
    endfunction

    // Byte lane inside the 32-bit word, with the low bits forced to the
    // natural alignment of the access size.
    function automatic logic [1:0] lane_offset(input logic [3:0] op, input logic [1:0] a);
        case (access_size(op))
            2'd0:    lane_offset = a;
            2'd1:    lane_offset = {a[1], 1'b0};
            default: lane_offset = 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
        case (access_size(op))
            2'd1:    is_misaligned = a[0];
            2'd2:    is_misaligned = (a != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    // Picks the addressed byte/half out of the returned word and extends it.
    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] a,
                                                 input logic [31:0] word);
        logic [1:0]  off;
        logic [7:0]  b;
        logic [15:0] h;
        off = lane_offset(op, a);
        b   = word[{off, 3'b000} +: 8];
        h   = word[{off[1], 4'b0000} +: 16];
        case (op)
            OP_LD_B:  load_extract = {{24{b[7]}}, b};
            OP_LD_BU: load_extract = {24'd0, b};
            OP_LD_H:  load_extract = {{16{h[15]}}, h};
            OP_LD_HU: load_extract = {16'd0, h};
            default:  load_extract = word;
        endcase
    endfunction

endpackage

// File: rtl/agu_store_buffer.sv
// Circular store buffer. Entries between head and commit pointer are retired
// by the ROB and may drain to memory; entries between commit and tail are
// still speculative and are rolled back on flush.
module agu_store_buffer
    import agu_exec_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push_i,
    input  sb_entry_t push_entry_i,
    input  logic      commit_i,
    input  logic      pop_i,
    output sb_entry_t head_entry_o,
    output logic      head_committed_o,
    output logic      empty_o,
    output logic      full_o
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam logic [PW:0] DEPTH_V = (PW + 1)'(SB_DEPTH);

    sb_entry_t   mem_q [SB_DEPTH];
    sb_entry_t   mem_d [SB_DEPTH];
    logic [PW:0] head_q, head_d;
    logic [PW:0] cmt_q, cmt_d;
    logic [PW:0] tail_q, tail_d;
    logic [PW:0] count;
    logic        push_ok, pop_ok, commit_ok;

    assign count            = tail_q - head_q;
    assign empty_o          = (count == '0);
    assign full_o           = (count == DEPTH_V);
    assign head_committed_o = (cmt_q != head_q);
    assign head_entry_o     = mem_q[head_q[PW-1:0]];

    // Pointer and storage update; a flush pulls tail back to the (possibly
    // just advanced) commit pointer so only retired stores survive.
    always_comb begin
        mem_d     = mem_q;
        push_ok   = push_i && !full_o;
        pop_ok    = pop_i && head_committed_o;
        commit_ok = commit_i && (cmt_q != tail_q);
        head_d    = head_q + {{PW{1'b0}}, pop_ok};
        cmt_d     = cmt_q + {{PW{1'b0}}, commit_ok};
        tail_d    = tail_q + {{PW{1'b0}}, push_ok};
        if (push_ok) begin
            mem_d[tail_q[PW-1:0]] = push_entry_i;
        end
        if (flush) begin
            tail_d = cmt_d;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
            mem_q  <= mem_d;
        end
    end

    // The issue queue never pushes into a full buffer; such a push is dropped
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push_i && full_o));
        end
    end

endmodule

// File: rtl/agu_exec.sv
// AGU execute stage: effective address, loads, buffered stores and cache/TLB
// maintenance, with back-pressure to the AGU issue queue.
// Optional: define AGU_MISALIGN_CHECK_EN to raise an exception on misaligned
// half/word accesses instead of silently aligning them.
module agu_exec
    import agu_exec_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        AGU_select_vld,
    input  logic [3:0]  AGU_select_op,
    input  logic [16:0] AGU_select_imm,
    input  logic        AGU_select_dest_en,
    input  logic [6:0]  AGU_select_dest,
    input  logic [6:0]  AGU_select_source1,
    input  logic [6:0]  AGU_select_source2,
    input  logic [5:0]  AGU_select_ROB_ID,
    output logic [6:0]  rf_raddr1,
    output logic [6:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic        AGU_busy,
    output logic        store_buffer_full,
    output logic        CACOP_already,
    output logic        INVTLB_already,
    input  logic        store_commit,
    output logic        mem_req_vld,
    input  logic        mem_req_rdy,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_resp_vld,
    input  logic [31:0] mem_resp_data,
    output logic        maint_req_vld,
    output logic        maint_is_tlb,
    output logic [31:0] maint_addr,
    input  logic        maint_done,
    output logic        wb_vld,
    output logic        wb_dest_en,
    output logic [6:0]  wb_dest,
    output logic [31:0] wb_data,
    output logic [5:0]  wb_ROB_ID,
    output logic        wb_exc
);

    agu_state_e  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic        dest_en_q, dest_en_d;
    logic [6:0]  dest_q, dest_d;
    logic [5:0]  rob_q, rob_d;
    logic        drop_q, drop_d;
    logic        kill_q, kill_d;
    logic        wb_vld_q, wb_vld_d;
    logic        wb_dest_en_q, wb_dest_en_d;
    logic [6:0]  wb_dest_q, wb_dest_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [5:0]  wb_rob_q, wb_rob_d;
    logic        wb_exc_q, wb_exc_d;

    logic [31:0] eff_addr;
    logic [1:0]  st_off;
    logic [3:0]  st_strb;
    logic        accept, is_load, is_store, is_maint, misalign, resp_take;
    logic        sb_push, sb_pop, sb_head_cmt, sb_empty, sb_full;
    sb_entry_t   sb_push_entry, sb_head;

    assign rf_raddr1         = AGU_select_source1;
    assign rf_raddr2         = AGU_select_source2;
    assign eff_addr          = rf_rdata1 + {{15{AGU_select_imm[16]}}, AGU_select_imm};
    assign AGU_busy          = (state_q != S_IDLE) || sb_head_cmt;
    assign accept            = AGU_select_vld && !AGU_busy && !flush;
    assign store_buffer_full = sb_full;
    assign CACOP_already     = ((state_q == S_WAIT_SB) || (state_q == S_MAINT)) && (op_q == OP_CACOP);
    assign INVTLB_already    = ((state_q == S_WAIT_SB) || (state_q == S_MAINT)) && (op_q == OP_INVTLB);
    assign maint_req_vld     = (state_q == S_MAINT);
    assign maint_is_tlb      = maint_req_vld && (op_q == OP_INVTLB);
    assign maint_addr        = maint_req_vld ? addr_q : 32'd0;
    assign resp_take         = mem_resp_vld && !drop_q;

    assign wb_vld     = wb_vld_q;
    assign wb_dest_en = wb_dest_en_q;
    assign wb_dest    = wb_dest_q;
    assign wb_data    = wb_data_q;
    assign wb_ROB_ID  = wb_rob_q;
    assign wb_exc     = wb_exc_q;

    // Decode of the selected instruction and the store-buffer entry it would push
    always_comb begin
        is_load  = (AGU_select_op <= OP_LD_HU);
        is_store = (AGU_select_op >= OP_ST_B) && (AGU_select_op <= OP_ST_W);
        is_maint = (AGU_select_op == OP_CACOP) || (AGU_select_op == OP_INVTLB);
`ifdef AGU_MISALIGN_CHECK_EN
        misalign = (is_load || is_store) && is_misaligned(AGU_select_op, eff_addr[1:0]);
`else
        misalign = 1'b0;
`endif
        st_off = lane_offset(AGU_select_op, eff_addr[1:0]);
        case (access_size(AGU_select_op))
            2'd0:    st_strb = 4'b0001 << st_off;
            2'd1:    st_strb = 4'b0011 << st_off;
            default: st_strb = 4'b1111;
        endcase
        sb_push_entry = '{addr: {eff_addr[31:2], 2'b00},
                          data: rf_rdata2 << {st_off, 3'b000},
                          strb: st_strb};
    end

    // Memory port: an outstanding load read wins, otherwise drain the
    // committed store-buffer head while nothing else is using the port
    always_comb begin
        mem_req_vld   = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = 32'd0;
        mem_req_wdata = 32'd0;
        mem_req_wstrb = 4'd0;
        sb_pop        = 1'b0;
        if (state_q == S_LD_REQ) begin
            mem_req_vld  = 1'b1;
            mem_req_addr = {addr_q[31:2], 2'b00};
        end else if (((state_q == S_IDLE) || (state_q == S_WAIT_SB)) && sb_head_cmt) begin
            mem_req_vld   = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_addr  = sb_head.addr;
            mem_req_wdata = sb_head.data;
            mem_req_wstrb = sb_head.strb;
            sb_pop        = mem_req_rdy;
        end
    end

    // Execute FSM next state, instruction capture and writeback generation
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        dest_en_d    = dest_en_q;
        dest_d       = dest_q;
        rob_d        = rob_q;
        drop_d       = drop_q;
        kill_d       = kill_q;
        wb_vld_d     = 1'b0;
        wb_dest_en_d = 1'b0;
        wb_dest_d    = 7'd0;
        wb_data_d    = 32'd0;
        wb_rob_d     = 6'd0;
        wb_exc_d     = 1'b0;
        sb_push      = 1'b0;
        if (mem_resp_vld && drop_q) begin
            drop_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d      = AGU_select_op;
                    addr_d    = eff_addr;
                    dest_en_d = AGU_select_dest_en;
                    dest_d    = AGU_select_dest;
                    rob_d     = AGU_select_ROB_ID;
                    if (!(is_load || is_store || is_maint) || misalign) begin
                        wb_vld_d = 1'b1;
                        wb_exc_d = 1'b1;
                        wb_rob_d = AGU_select_ROB_ID;
                    end else if (is_store) begin
                        sb_push  = 1'b1;
                        wb_vld_d = 1'b1;
                        wb_rob_d = AGU_select_ROB_ID;
                    end else if (!sb_empty) begin
                        state_d = S_WAIT_SB;
                    end else if (is_maint) begin
                        state_d = S_MAINT;
                    end else begin
                        state_d = S_LD_REQ;
                    end
                end
            end
            S_WAIT_SB: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (sb_empty) begin
                    state_d = ((op_q == OP_CACOP) || (op_q == OP_INVTLB)) ? S_MAINT : S_LD_REQ;
                end
            end
            S_LD_REQ: begin
                if (flush) begin
                    state_d = S_IDLE;
                    if (mem_req_rdy) begin
                        drop_d = 1'b1;
                    end
                end else if (mem_req_rdy) begin
                    state_d = S_LD_RESP;
                end
            end
            S_LD_RESP: begin
                if (flush) begin
                    state_d = S_IDLE;
                    if (!resp_take) begin
                        drop_d = 1'b1;
                    end
                end else if (resp_take) begin
                    state_d      = S_IDLE;
                    wb_vld_d     = 1'b1;
                    wb_dest_en_d = dest_en_q;
                    wb_dest_d    = dest_q;
                    wb_rob_d     = rob_q;
                    wb_data_d    = load_extract(op_q, addr_q[1:0], mem_resp_data);
                end
            end
            S_MAINT: begin
                kill_d = kill_q || flush;
                if (maint_done) begin
                    state_d = S_IDLE;
                    kill_d  = 1'b0;
                    if (!(kill_q || flush)) begin
                        wb_vld_d     = 1'b1;
                        wb_dest_en_d = dest_en_q;
                        wb_dest_d    = dest_q;
                        wb_rob_d     = rob_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 4'd0;
            addr_q       <= 32'd0;
            dest_en_q    <= 1'b0;
            dest_q       <= 7'd0;
            rob_q        <= 6'd0;
            drop_q       <= 1'b0;
            kill_q       <= 1'b0;
            wb_vld_q     <= 1'b0;
            wb_dest_en_q <= 1'b0;
            wb_dest_q    <= 7'd0;
            wb_data_q    <= 32'd0;
            wb_rob_q     <= 6'd0;
            wb_exc_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            dest_en_q    <= dest_en_d;
            dest_q       <= dest_d;
            rob_q        <= rob_d;
            drop_q       <= drop_d;
            kill_q       <= kill_d;
            wb_vld_q     <= wb_vld_d;
            wb_dest_en_q <= wb_dest_en_d;
            wb_dest_q    <= wb_dest_d;
            wb_data_q    <= wb_data_d;
            wb_rob_q     <= wb_rob_d;
            wb_exc_q     <= wb_exc_d;
        end
    end

    agu_store_buffer #(.SB_DEPTH(SB_DEPTH)) u_sb (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .push_i           (sb_push),
        .push_entry_i     (sb_push_entry),
        .commit_i         (store_commit),
        .pop_i            (sb_pop),
        .head_entry_o     (sb_head),
        .head_committed_o (sb_head_cmt),
        .empty_o          (sb_empty),
        .full_o           (sb_full)
    );

endmodule

// File: tb/tb_agu_exec.sv
// Directed bench for agu_exec: table of load vectors plus hand-written
// store-buffer, flush and maintenance sequences.
module tb_agu_exec;
    import agu_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        AGU_select_vld;
    logic [3:0]  AGU_select_op;
    logic [16:0] AGU_select_imm;
    logic        AGU_select_dest_en;
    logic [6:0]  AGU_select_dest;
    logic [6:0]  AGU_select_source1;
    logic [6:0]  AGU_select_source2;
    logic [5:0]  AGU_select_ROB_ID;
    logic [6:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        AGU_busy, store_buffer_full, CACOP_already, INVTLB_already;
    logic        store_commit;
    logic        mem_req_vld, mem_req_rdy, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_vld;
    logic [31:0] mem_resp_data;
    logic        maint_req_vld, maint_is_tlb, maint_done;
    logic [31:0] maint_addr;
    logic        wb_vld, wb_dest_en, wb_exc;
    logic [6:0]  wb_dest;
    logic [31:0] wb_data;
    logic [5:0]  wb_ROB_ID;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] r1;
        logic [16:0] imm;
        logic [31:0] resp;
        logic        chk_addr;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        int          stall;
    } load_vec_t;

    load_vec_t vecs [9];

    agu_exec dut (
        .clk(clk), .rst(rst), .flush(flush),
        .AGU_select_vld(AGU_select_vld), .AGU_select_op(AGU_select_op),
        .AGU_select_imm(AGU_select_imm), .AGU_select_dest_en(AGU_select_dest_en),
        .AGU_select_dest(AGU_select_dest), .AGU_select_source1(AGU_select_source1),
        .AGU_select_source2(AGU_select_source2), .AGU_select_ROB_ID(AGU_select_ROB_ID),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .AGU_busy(AGU_busy), .store_buffer_full(store_buffer_full),
        .CACOP_already(CACOP_already), .INVTLB_already(INVTLB_already),
        .store_commit(store_commit),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_vld(mem_resp_vld), .mem_resp_data(mem_resp_data),
        .maint_req_vld(maint_req_vld), .maint_is_tlb(maint_is_tlb),
        .maint_addr(maint_addr), .maint_done(maint_done),
        .wb_vld(wb_vld), .wb_dest_en(wb_dest_en), .wb_dest(wb_dest),
        .wb_data(wb_data), .wb_ROB_ID(wb_ROB_ID), .wb_exc(wb_exc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Presents one instruction for a single cycle; the clock edge accepts it
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [16:0] imm, input logic [5:0] rob, input logic [6:0] dest);
        AGU_select_vld     = 1'b1;
        AGU_select_op      = op;
        AGU_select_imm     = imm;
        AGU_select_dest_en = 1'b1;
        AGU_select_dest    = dest;
        AGU_select_source1 = 7'd1;
        AGU_select_source2 = 7'd2;
        AGU_select_ROB_ID  = rob;
        rf_rdata1          = r1;
        rf_rdata2          = r2;
        tick();
        AGU_select_vld     = 1'b0;
    endtask

    task automatic run_load(input load_vec_t v, input logic [5:0] rob);
        logic [6:0] dest;
        dest = 7'(rob) + 7'd10;
        applyStimulus(v.op, v.r1, 32'd0, v.imm, rob, dest);
        checkOutput("ld_req_vld", {31'd0, mem_req_vld}, 32'd1);
        checkOutput("ld_req_we", {31'd0, mem_req_we}, 32'd0);
        checkOutput("ld_busy", {31'd0, AGU_busy}, 32'd1);
        if (v.chk_addr) checkOutput("ld_req_addr", mem_req_addr, v.exp_addr);
        for (int s = 0; s < v.stall; s++) begin
            tick();
            checkOutput("ld_req_hold", {31'd0, mem_req_vld}, 32'd1);
        end
        mem_req_rdy = 1'b1;
        tick();
        mem_req_rdy = 1'b0;
        checkOutput("ld_no_early_wb", {31'd0, wb_vld}, 32'd0);
        mem_resp_vld  = 1'b1;
        mem_resp_data = v.resp;
        tick();
        mem_resp_vld  = 1'b0;
        checkOutput("ld_wb_vld", {31'd0, wb_vld}, 32'd1);
        checkOutput("ld_wb_data", wb_data, v.exp_data);
        checkOutput("ld_wb_rob", {26'd0, wb_ROB_ID}, {26'd0, rob});
        checkOutput("ld_wb_dest", {25'd0, wb_dest}, {25'd0, dest});
        checkOutput("ld_wb_exc", {31'd0, wb_exc}, 32'd0);
        checkOutput("ld_idle_busy", {31'd0, AGU_busy}, 32'd0);
        tick();
        checkOutput("ld_wb_pulse", {31'd0, wb_vld}, 32'd0);
    endtask

    initial begin
        load_vec_t lv;
        vecs[0] = '{OP_LD_W,  32'h0000_1000, 17'h1FFFC, 32'hDEAD_BEEF, 1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF, 0};
        vecs[1] = '{OP_LD_B,  32'h0000_2000, 17'h00003, 32'h8000_0000, 1'b0, 32'h0,         32'hFFFF_FF80, 0};
        vecs[2] = '{OP_LD_BU, 32'h0000_2000, 17'h00003, 32'h8000_0000, 1'b0, 32'h0,         32'h0000_0080, 2};
        vecs[3] = '{OP_LD_H,  32'h0000_3000, 17'h00002, 32'h8001_1234, 1'b0, 32'h0,         32'hFFFF_8001, 0};
        vecs[4] = '{OP_LD_HU, 32'h0000_3000, 17'h00002, 32'h8001_1234, 1'b0, 32'h0,         32'h0000_8001, 0};
        vecs[5] = '{OP_LD_H,  32'h0000_4000, 17'h00000, 32'h1234_F00D, 1'b1, 32'h0000_4000, 32'hFFFF_F00D, 1};
        vecs[6] = '{OP_LD_B,  32'h0000_5000, 17'h1FFFF, 32'h7F00_0000, 1'b0, 32'h0,         32'h0000_007F, 0};
        vecs[7] = '{OP_LD_W,  32'hFFFF_FFF0, 17'h00010, 32'h1234_5678, 1'b1, 32'h0000_0000, 32'h1234_5678, 0};
        vecs[8] = '{OP_LD_BU, 32'h0000_6000, 17'h00001, 32'h0000_A500, 1'b0, 32'h0,         32'h0000_00A5, 0};

        rst = 1'b1; flush = 1'b0; AGU_select_vld = 1'b0; AGU_select_op = 4'd0;
        AGU_select_imm = '0; AGU_select_dest_en = 1'b0; AGU_select_dest = '0;
        AGU_select_source1 = '0; AGU_select_source2 = '0; AGU_select_ROB_ID = '0;
        rf_rdata1 = '0; rf_rdata2 = '0; store_commit = 1'b0; mem_req_rdy = 1'b0;
        mem_resp_vld = 1'b0; mem_resp_data = '0; maint_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        checkOutput("rst_busy", {31'd0, AGU_busy}, 32'd0);
        checkOutput("rst_full", {31'd0, store_buffer_full}, 32'd0);
        checkOutput("rst_mem_vld", {31'd0, mem_req_vld}, 32'd0);
        checkOutput("rst_maint_vld", {31'd0, maint_req_vld}, 32'd0);
        checkOutput("rst_wb_vld", {31'd0, wb_vld}, 32'd0);
        checkOutput("rst_cacop", {31'd0, CACOP_already}, 32'd0);

        // Four word stores fill the buffer without draining
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_ST_W, 32'h100 * (i + 1), 32'hA000_0000 + i, 17'd0, 6'(20 + i), 7'd0);
            checkOutput("st_wb_vld", {31'd0, wb_vld}, 32'd1);
            checkOutput("st_wb_dest_en", {31'd0, wb_dest_en}, 32'd0);
            checkOutput("st_wb_rob", {26'd0, wb_ROB_ID}, 32'(20 + i));
            checkOutput("st_full", {31'd0, store_buffer_full}, (i == 3) ? 32'd1 : 32'd0);
        end
        checkOutput("st_no_drain", {31'd0, mem_req_vld}, 32'd0);
        checkOutput("st_uncommitted_busy", {31'd0, AGU_busy}, 32'd0);
        store_commit = 1'b1;
        tick();
        checkOutput("drain_vld", {31'd0, mem_req_vld}, 32'd1);
        checkOutput("drain_we", {31'd0, mem_req_we}, 32'd1);
        checkOutput("drain_addr0", mem_req_addr, 32'h0000_0100);
        checkOutput("drain_data0", mem_req_wdata, 32'hA000_0000);
        checkOutput("drain_strb0", {28'd0, mem_req_wstrb}, 32'hF);
        checkOutput("drain_busy", {31'd0, AGU_busy}, 32'd1);
        tick();
        store_commit = 1'b0;
        mem_req_rdy  = 1'b1;
        tick();
        checkOutput("drain_full_clear", {31'd0, store_buffer_full}, 32'd0);
        checkOutput("drain_addr1", mem_req_addr, 32'h0000_0200);
        checkOutput("drain_data1", mem_req_wdata, 32'hA000_0001);
        tick();
        mem_req_rdy = 1'b0;
        checkOutput("drain_done_vld", {31'd0, mem_req_vld}, 32'd0);
        checkOutput("drain_done_busy", {31'd0, AGU_busy}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Load table; the first load also proves the flush emptied the buffer
        for (int i = 0; i < 9; i++) begin
            run_load(vecs[i], 6'(i));
        end

        // Byte store, then a load held behind it until the store drains
        applyStimulus(OP_ST_B, 32'h0000_2000, 32'h0000_0055, 17'd1, 6'd30, 7'd0);
        checkOutput("stb_wb_vld", {31'd0, wb_vld}, 32'd1);
        applyStimulus(OP_LD_W, 32'h0000_3000, 32'd0, 17'd0, 6'd31, 7'd5);
        checkOutput("waitsb_busy", {31'd0, AGU_busy}, 32'd1);
        checkOutput("waitsb_no_req", {31'd0, mem_req_vld}, 32'd0);
        tick();
        checkOutput("waitsb_hold", {31'd0, mem_req_vld}, 32'd0);
        store_commit = 1'b1;
        tick();
        store_commit = 1'b0;
        checkOutput("waitsb_drain_we", {31'd0, mem_req_we}, 32'd1);
        checkOutput("waitsb_drain_addr", mem_req_addr, 32'h0000_2000);
        checkOutput("waitsb_drain_data", mem_req_wdata, 32'h0000_5500);
        checkOutput("waitsb_drain_strb", {28'd0, mem_req_wstrb}, 32'h2);
        mem_req_rdy = 1'b1;
        tick();
        mem_req_rdy = 1'b0;
        checkOutput("waitsb_empty_no_req", {31'd0, mem_req_vld}, 32'd0);
        tick();
        checkOutput("waitsb_ld_req", {31'd0, mem_req_vld}, 32'd1);
        checkOutput("waitsb_ld_we", {31'd0, mem_req_we}, 32'd0);
        checkOutput("waitsb_ld_addr", mem_req_addr, 32'h0000_3000);
        mem_req_rdy = 1'b1;
        tick();
        mem_req_rdy   = 1'b0;
        mem_resp_vld  = 1'b1;
        mem_resp_data = 32'hCAFE_0001;
        tick();
        mem_resp_vld  = 1'b0;
        checkOutput("waitsb_wb_data", wb_data, 32'hCAFE_0001);
        checkOutput("waitsb_wb_rob", {26'd0, wb_ROB_ID}, 32'd31);
        tick();

        // Flush while waiting for the response; the late response is dropped
        applyStimulus(OP_LD_W, 32'h0000_4000, 32'd0, 17'd0, 6'd40, 7'd1);
        mem_req_rdy = 1'b1;
        tick();
        mem_req_rdy = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_resp_busy", {31'd0, AGU_busy}, 32'd0);
        checkOutput("flush_resp_no_wb", {31'd0, wb_vld}, 32'd0);
        mem_resp_vld  = 1'b1;
        mem_resp_data = 32'h0BAD_0BAD;
        tick();
        mem_resp_vld  = 1'b0;
        checkOutput("late_resp_dropped", {31'd0, wb_vld}, 32'd0);
        lv = '{OP_LD_W, 32'h0000_7000, 17'd4, 32'h600D_F00D, 1'b1, 32'h0000_7004, 32'h600D_F00D, 0};
        run_load(lv, 6'd41);

        // An instruction offered in a flush cycle is not accepted
        AGU_select_vld = 1'b1;
        AGU_select_op  = OP_LD_W;
        flush          = 1'b1;
        tick();
        AGU_select_vld = 1'b0;
        flush          = 1'b0;
        checkOutput("flush_accept_busy", {31'd0, AGU_busy}, 32'd0);
        checkOutput("flush_accept_req", {31'd0, mem_req_vld}, 32'd0);

        // CACOP: flag and busy until the cycle after maint_done
        applyStimulus(OP_CACOP, 32'h0000_8000, 32'd0, 17'h10, 6'd50, 7'd0);
        checkOutput("cacop_req", {31'd0, maint_req_vld}, 32'd1);
        checkOutput("cacop_addr", maint_addr, 32'h0000_8010);
        checkOutput("cacop_is_tlb", {31'd0, maint_is_tlb}, 32'd0);
        checkOutput("cacop_already", {31'd0, CACOP_already}, 32'd1);
        checkOutput("cacop_invtlb_flag", {31'd0, INVTLB_already}, 32'd0);
        checkOutput("cacop_busy", {31'd0, AGU_busy}, 32'd1);
        tick();
        maint_done = 1'b1;
        checkOutput("cacop_done_cycle_flag", {31'd0, CACOP_already}, 32'd1);
        tick();
        maint_done = 1'b0;
        checkOutput("cacop_wb_vld", {31'd0, wb_vld}, 32'd1);
        checkOutput("cacop_wb_rob", {26'd0, wb_ROB_ID}, 32'd50);
        checkOutput("cacop_flag_clear", {31'd0, CACOP_already}, 32'd0);
        checkOutput("cacop_busy_clear", {31'd0, AGU_busy}, 32'd0);
        tick();

        // INVTLB flushed mid-flight: still waits for done, no writeback
        applyStimulus(OP_INVTLB, 32'h0000_9000, 32'd0, 17'd0, 6'd51, 7'd0);
        checkOutput("invtlb_already", {31'd0, INVTLB_already}, 32'd1);
        checkOutput("invtlb_is_tlb", {31'd0, maint_is_tlb}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("invtlb_held", {31'd0, maint_req_vld}, 32'd1);
        maint_done = 1'b1;
        tick();
        maint_done = 1'b0;
        checkOutput("invtlb_no_wb", {31'd0, wb_vld}, 32'd0);
        checkOutput("invtlb_flag_clear", {31'd0, INVTLB_already}, 32'd0);
        checkOutput("invtlb_busy_clear", {31'd0, AGU_busy}, 32'd0);

        // Undefined op completes next cycle with an exception
        applyStimulus(4'd12, 32'd0, 32'd0, 17'd0, 6'd60, 7'd0);
        checkOutput("badop_wb_vld", {31'd0, wb_vld}, 32'd1);
        checkOutput("badop_wb_exc", {31'd0, wb_exc}, 32'd1);
        checkOutput("badop_busy", {31'd0, AGU_busy}, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
